alu_operand_entry: RTL and testbench
====================================

// Module: alu_operand_entry
// PURPOSE
//  Front-end sequencer that sits directly upstream of the 8-bit ALU/multiplier datapath.
//  It debounces the raw push-button, converts each press into a single-cycle pulse, and
//  walks the user through opcode -> operand A -> operand B entry from the 8 slide switches.
//  Operands are presented atomically with a 1-cycle issue strobe; completion is then timed
//  (multiply needs MUL_LAT cycles) before done/op_valid are signalled.
// PARAMETERS
//  DB_CYCLES  16  consecutive stable cycles of synced button required to accept a new level
//  MUL_LAT    8   cycles from issue to done when opcode == 4'hC (sequential multiply)
//  OPC_MAX    13  largest legal opcode; 4'hE/4'hF rejected (4'hF reserved = ALU reset/idle)
// PORTS
//  clk        in   1  clock, all logic on rising edge
//  rst        in   1  reset, asynchronous, active-high
//  enter_raw  in   1  raw push-button, asynchronous, bouncy, active-high
//  switch     in   8  slide switches; [3:0] used for opcode, [7:0] for operands
//  opcode_o   out  4  opcode presented to ALU
//  op_a       out  8  operand A presented to ALU
//  op_b       out  8  operand B presented to ALU
//  issue      out  1  1-cycle strobe: opcode_o/op_a/op_b updated this cycle
//  done       out  1  1-cycle strobe: ALU result now valid
//  op_valid   out  1  level: result valid, held in S_HOLD
//  err        out  1  1-cycle strobe: illegal opcode entered
//  state_o    out  3  current FSM state encoding (for LEDs)
// BEHAVIOUR
//  Reset: opcode_o=4'hF, op_a=op_b=0, issue=done=op_valid=err=0, state=S_OPC (0),
//   synchronizer/debounce counter/staging regs cleared, arm=0.
//  Button path: 2-flop sync -> debounce counter; counter clears on any change of synced
//   value vs debounced level, debounced level takes synced value when counter hits
//   DB_CYCLES-1. enter_pulse = rising edge of debounced level AND arm. arm sets once
//   debounced level is seen 0. A button held through reset release never produces a pulse;
//   it must be released then pressed. Raw rise to enter_pulse = DB_CYCLES+3 cycles.
//   Glitches shorter than DB_CYCLES never produce a pulse. Release produces no pulse.
//  FSM (state_o): S_OPC=0, S_OPA=1, S_OPB=2, S_EXEC=3, S_HOLD=4.
//   S_OPC : on enter_pulse, if switch[3:0] > OPC_MAX -> err=1 for that cycle, stay;
//           else stage opcode, -> S_OPA.
//   S_OPA : on enter_pulse stage switch -> A, -> S_OPB.
//   S_OPB : on enter_pulse stage switch -> B; next edge: opcode_o/op_a/op_b load from
//           staging together, issue=1, wait counter loaded, -> S_EXEC.
//   S_EXEC: wait MUL_LAT cycles if opcode_o==4'hC, else 1 cycle; then done=1 (1 cycle),
//           op_valid=1, -> S_HOLD. enter_pulse in S_EXEC is dropped.
//   S_HOLD: op_valid held 1, outputs stable; on enter_pulse op_valid=0, -> S_OPC.
//  Outputs opcode_o/op_a/op_b change only on issue; they keep last values through
//   S_OPC/S_OPA/S_OPB re-entry so the ALU never sees a half-entered operation.
//  Switch values sampled only on the enter_pulse cycle; switch activity otherwise ignored.
//  Mid-operation reset: everything returns to reset values immediately (async), in-flight
//   staging discarded, no done issued.
//  Wait counter width = clog2(MUL_LAT)+1; MUL_LAT >= 1 required.
// TESTING
//  1. Clean press: switch=4'h1 press, 8'h05 press, 8'h03 press -> issue 1 cycle with
//     opcode_o=1, op_a=5, op_b=3; done 1 cycle later; op_valid=1, state_o=4.
//  2. Bounce: toggle enter_raw every 3 cycles x6, then hold 40 cycles (DB_CYCLES=16)
//     -> exactly one enter_pulse, state_o 0->1 only.
//  3. Illegal opcode: switch=4'hE press -> err pulse 1 cycle, state_o stays 0, opcode_o=4'hF.
//  4. Multiply: opcode 4'hC, A=8'h0F, B=8'h0A -> done exactly MUL_LAT=8 cycles after issue;
//     extra press during S_EXEC ignored (state_o stays 3).
//  5. Reset mid-entry: assert rst in S_OPB with button held -> all outputs to reset values;
//     no pulse until button released and re-pressed.
//  6. Atomic update: after test 1, enter new opcode/A (stop in S_OPB) -> opcode_o/op_a/op_b
//     still 1/5/3 until issue.

Source files
------------

// File: rtl/alu_operand_entry.sv
// Operand-entry sequencer in front of the 8-bit ALU: debounces the enter button and walks
// opcode -> A -> B entry, then issues all three atomically and times the result.
module alu_operand_entry #(
    parameter int DB_CYCLES = 16,
    parameter int MUL_LAT   = 8,
    parameter int OPC_MAX   = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enter_raw,
    input  logic [7:0] switch,
    output logic [3:0] opcode_o,
    output logic [7:0] op_a,
    output logic [7:0] op_b,
    output logic       issue,
    output logic       done,
    output logic       op_valid,
    output logic       err,
    output logic [2:0] state_o
);

    localparam int DB_W   = $clog2(DB_CYCLES) + 1;
    localparam int WAIT_W = $clog2(MUL_LAT) + 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_MUL  = WAIT_W'(MUL_LAT);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [3:0]        OPC_LIMIT = 4'(OPC_MAX);
    localparam logic [3:0]        OPC_MUL   = 4'hC;
    localparam logic [3:0]        OPC_IDLE  = 4'hF;

    typedef enum logic [2:0] {
        S_OPC  = 3'd0,
        S_OPA  = 3'd1,
        S_OPB  = 3'd2,
        S_EXEC = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    // Button path
    logic            r_sync1;
    logic            r_sync2;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_db;
    logic            r_db_d;
    logic            r_arm;
    logic            w_enter_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_db_cnt <= '0;
            // Debounced level starts high so a button held through reset must be seen
            // released (level falls, arm sets) before any press can produce a pulse.
            r_db     <= 1'b1;
            r_db_d   <= 1'b1;
            r_arm    <= 1'b0;
        end else begin
            r_sync1 <= enter_raw;
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;
            if (r_sync2 != r_db) begin
                if (r_db_cnt == DB_LAST) begin
                    r_db     <= r_sync2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
            if (!r_db) r_arm <= 1'b1;
        end
    end

    assign w_enter_pulse = r_db & ~r_db_d & r_arm;

    // Sequencer
    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_stg_opc;
    logic [7:0]          r_stg_a;
    logic [7:0]          r_stg_b;
    logic                r_go;
    logic [WAIT_W-1:0]   r_wait;
    logic                r_issue;
    logic                r_done;
    logic                r_err;
    logic                r_op_valid;
    logic [3:0]          r_opcode;
    logic [7:0]          r_op_a;
    logic [7:0]          r_op_b;

    logic w_stage_opc;
    logic w_stage_a;
    logic w_stage_b;
    logic w_load;
    logic w_err;
    logic w_done;
    logic w_clr_valid;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        w_state_nxt = r_state;
        w_stage_opc = 1'b0;
        w_stage_a   = 1'b0;
        w_stage_b   = 1'b0;
        w_load      = 1'b0;
        w_err       = 1'b0;
        w_done      = 1'b0;
        w_clr_valid = 1'b0;
        case (r_state)
            S_OPC: begin
                if (w_enter_pulse) begin
                    if (switch[3:0] > OPC_LIMIT) begin
                        w_err = 1'b1;
                    end else begin
                        w_stage_opc = 1'b1;
                        w_state_nxt = S_OPA;
                    end
                end
            end
            S_OPA: begin
                if (w_enter_pulse) begin
                    w_stage_a   = 1'b1;
                    w_state_nxt = S_OPB;
                end
            end
            S_OPB: begin
                if (r_go) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_EXEC;
                end else if (w_enter_pulse) begin
                    w_stage_b = 1'b1;
                end
            end
            S_EXEC: begin
                // Presses during execution are intentionally dropped.
                if (r_wait == WAIT_ONE) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_enter_pulse) begin
                    w_clr_valid = 1'b1;
                    w_state_nxt = S_OPC;
                end
            end
            default: w_state_nxt = S_OPC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_OPC;
            r_stg_opc  <= '0;
            r_stg_a    <= '0;
            r_stg_b    <= '0;
            r_go       <= 1'b0;
            r_wait     <= '0;
            r_issue    <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_op_valid <= 1'b0;
            r_opcode   <= OPC_IDLE;
            r_op_a     <= '0;
            r_op_b     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_go    <= w_stage_b;
            r_issue <= w_load;
            r_done  <= w_done;
            r_err   <= w_err;
            if (w_stage_opc) r_stg_opc <= switch[3:0];
            if (w_stage_a)   r_stg_a   <= switch;
            if (w_stage_b)   r_stg_b   <= switch;
            // Presented operands move only here, all three together.
            if (w_load) begin
                r_opcode <= r_stg_opc;
                r_op_a   <= r_stg_a;
                r_op_b   <= r_stg_b;
                r_wait   <= (r_stg_opc == OPC_MUL) ? WAIT_MUL : WAIT_ONE;
            end else if (r_state == S_EXEC) begin
                r_wait <= r_wait - 1'b1;
            end
            if (w_done) begin
                r_op_valid <= 1'b1;
            end else if (w_clr_valid) begin
                r_op_valid <= 1'b0;
            end
        end
    end

    assign opcode_o = r_opcode;
    assign op_a     = r_op_a;
    assign op_b     = r_op_b;
    assign issue    = r_issue;
    assign done     = r_done;
    assign op_valid = r_op_valid;
    assign err      = r_err;
    assign state_o  = r_state;

endmodule

// File: tb/tb_alu_operand_entry.sv
// Directed bench for alu_operand_entry: entry sequence, bounce, illegal opcode, multiply
// latency, reset with the button held, and atomic operand update.
module tb_alu_operand_entry;

    logic       clk;
    logic       rst;
    logic       enter_raw;
    logic [7:0] switch;
    logic [3:0] opcode_o;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       issue;
    logic       done;
    logic       op_valid;
    logic       err;
    logic [2:0] state_o;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc       = 0;
    int n_issue   = 0;
    int n_done    = 0;
    int n_err     = 0;
    int issue_cyc = 0;
    int done_cyc  = 0;
    int exec_cnt  = 0;

    alu_operand_entry #(
        .DB_CYCLES(16),
        .MUL_LAT  (8),
        .OPC_MAX  (13)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enter_raw(enter_raw),
        .switch   (switch),
        .opcode_o (opcode_o),
        .op_a     (op_a),
        .op_b     (op_b),
        .issue    (issue),
        .done     (done),
        .op_valid (op_valid),
        .err      (err),
        .state_o  (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitor, sampled shortly after each rising edge.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            cyc++;
            if (issue) begin
                n_issue++;
                issue_cyc = cyc;
                exec_cnt  = 0;
            end
            if (state_o == 3'd3) exec_cnt++;
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (err) n_err++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Clean press: held long enough to debounce, then released long enough to re-arm.
    task automatic press(input logic [7:0] val);
        switch    = val;
        enter_raw = 1'b1;
        repeat (25) @(negedge clk);
        enter_raw = 1'b0;
        repeat (25) @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        enter_raw = 1'b0;
        switch    = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_opcode",   32'(opcode_o), 32'hF);
        check("rst_op_a",     32'(op_a),     32'h0);
        check("rst_op_b",     32'(op_b),     32'h0);
        check("rst_strobes",  32'({issue, done, op_valid, err}), 32'h0);
        check("rst_state",    32'(state_o),  32'h0);
        rst = 1'b0;
        repeat (30) @(negedge clk);

        // Illegal opcode straight after reset
        press(8'h0E);
        check("ill_err_cnt", 32'(n_err),    32'd1);
        check("ill_state",   32'(state_o),  32'h0);
        check("ill_opcode",  32'(opcode_o), 32'hF);

        // Clean entry 1 / 5 / 3
        press(8'h01);
        check("t1_state_a", 32'(state_o), 32'h1);
        press(8'h05);
        check("t1_state_b", 32'(state_o), 32'h2);
        press(8'h03);
        check("t1_issue_cnt", 32'(n_issue),  32'd1);
        check("t1_opcode",    32'(opcode_o), 32'h1);
        check("t1_op_a",      32'(op_a),     32'h05);
        check("t1_op_b",      32'(op_b),     32'h03);
        check("t1_done_cnt",  32'(n_done),   32'd1);
        check("t1_done_lat",  32'(done_cyc - issue_cyc), 32'd1);
        check("t1_exec_cyc",  32'(exec_cnt), 32'd1);
        check("t1_valid",     32'(op_valid), 32'h1);
        check("t1_state",     32'(state_o),  32'h4);

        // Atomic update: new entry must not disturb presented operands until issue
        press(8'h00);
        check("t6_leave_hold", 32'(state_o),  32'h0);
        check("t6_valid_clr",  32'(op_valid), 32'h0);
        press(8'h02);
        check("t6_opc_held",   32'(opcode_o), 32'h1);
        press(8'h22);
        check("t6_state_b",    32'(state_o),  32'h2);
        check("t6_ops_held",   32'({opcode_o, op_a, op_b}), 32'h10503);
        press(8'h33);
        check("t6_ops_new",    32'({opcode_o, op_a, op_b}), 32'h22233);
        check("t6_issue_cnt",  32'(n_issue),  32'd2);
        press(8'h00);
        check("t2_pre_state",  32'(state_o),  32'h0);

        // Bounce: six 3-cycle toggles, then a steady hold -> exactly one pulse
        switch = 8'h0C;
        for (int i = 0; i < 6; i++) begin
            enter_raw = ~enter_raw;
            repeat (3) @(negedge clk);
        end
        enter_raw = 1'b1;
        repeat (40) @(negedge clk);
        enter_raw = 1'b0;
        repeat (25) @(negedge clk);
        check("t2_one_pulse", 32'(state_o), 32'h1);

        // Glitch one cycle short of the debounce window
        switch    = 8'hAA;
        enter_raw = 1'b1;
        repeat (15) @(negedge clk);
        enter_raw = 1'b0;
        repeat (25) @(negedge clk);
        check("glitch_ignored", 32'(state_o), 32'h1);

        // Multiply: opcode C staged during the bounce test
        press(8'h0F);
        check("t4_state_b", 32'(state_o), 32'h2);
        press(8'h0A);
        check("t4_ops",      32'({opcode_o, op_a, op_b}), 32'hC0F0A);
        check("t4_done_lat", 32'(done_cyc - issue_cyc), 32'd8);
        check("t4_exec_cyc", 32'(exec_cnt), 32'd8);
        check("t4_done_cnt", 32'(n_done),   32'd3);
        check("t4_valid",    32'(op_valid), 32'h1);
        check("t4_state",    32'(state_o),  32'h4);

        // Reset in S_OPB with the button held
        press(8'h00);
        press(8'h03);
        press(8'h07);
        check("t5_state_b", 32'(state_o), 32'h2);
        enter_raw = 1'b1;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_opcode", 32'(opcode_o), 32'hF);
        check("t5_rst_ops",    32'({op_a, op_b}), 32'h0);
        check("t5_rst_flags",  32'({issue, done, op_valid, err}), 32'h0);
        check("t5_rst_state",  32'(state_o),  32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("t5_held_state", 32'(state_o), 32'h0);
        check("t5_no_issue",   32'(n_issue), 32'd3);
        check("t5_no_done",    32'(n_done),  32'd3);
        enter_raw = 1'b0;
        repeat (25) @(negedge clk);
        press(8'h0D);
        check("t5_repress_max_opc", 32'(state_o), 32'h1);
        check("t5_no_err",          32'(n_err),   32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
